// File: rtl/apb_slave_mem_responder_pkg.sv
// Shared types for the APB memory responder.
// Response FSM states, bus encodings and wait-state limits.
package apb_slave_mem_responder_pkg;

   typedef enum logic {
      SLV_OKAY  = 1'b0,
      SLV_ERROR = 1'b1
   } slave_error_e;

   typedef enum logic {
      TX_READ  = 1'b0,
      TX_WRITE = 1'b1
   } tx_type_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      ACCESS = 2'b10
   } apb_resp_state_e;

   localparam int unsigned MAX_WAIT_STATES = 15;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT_STATES + 1);

endpackage

// File: rtl/apb_slave_mem_array.sv
// Byte-lane-enabled register array with synchronous clear.
// One write port, one combinational read port.
module apb_slave_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 64,
   parameter int IDX_W      = 6
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    we,
   input  logic [IDX_W-1:0]        waddr,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [IDX_W-1:0]        raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int BYTES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wstrb[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB4 completer backed by a word-addressed memory.
// Programmable wait states, pslverr on bad address, sticky protocol_err.
module apb_slave_mem_responder
   import apb_slave_mem_responder_pkg::*;
#(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     MEM_DEPTH     = 64,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = '0
) (
   input  logic                     pclk,
   input  logic                     preset,
   input  logic                     psel,
   input  logic                     penable,
   input  logic                     pwrite,
   input  logic [ADDRESS_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0]    pwdata,
   input  logic [DATA_WIDTH/8-1:0]  pstrb,
   input  logic [2:0]               pprot,
   input  logic [WAIT_W-1:0]        cfg_wait_states,
   output logic [DATA_WIDTH-1:0]    prdata,
   output logic                     pready,
   output logic                     pslverr,
   output logic                     protocol_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDRESS_WIDTH:0] SPAN =
      (ADDRESS_WIDTH+1)'(MEM_DEPTH * BYTES);
   localparam logic [ADDRESS_WIDTH-1:0] LANE_MASK =
      ADDRESS_WIDTH'(BYTES - 1);

   typedef struct packed {
      tx_type_e                 write;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    wdata;
      logic [BYTES-1:0]         strb;
      logic [2:0]               prot;
   } req_t;

   apb_resp_state_e       state_q, state_d;
   req_t                  req_q, req_d, cap;
   logic [WAIT_W-1:0]     wait_q, wait_d;
   logic                  first_q, first_d;
   logic                  pready_d, perr_d, respond, mem_we;
   slave_error_e          pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] prdata_d, rd_data;
   logic [ADDRESS_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      widx;
   logic                  in_range, aligned, addr_err;

   // Decode always works on the captured address, never the live bus.
   assign offset   = req_q.addr - BASE_ADDR;
   assign in_range = (req_q.addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
   assign aligned  = (req_q.addr & LANE_MASK) == '0;
   assign addr_err = !(in_range && aligned);
   assign widx     = offset[LSB +: IDX_W];

   apb_slave_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .clk   (pclk),
      .clr   (preset),
      .we    (mem_we),
      .waddr (widx),
      .wstrb (req_q.strb),
      .wdata (req_q.wdata),
      .raddr (widx),
      .rdata (rd_data)
   );

   always_comb begin
      cap = '{write: tx_type_e'(pwrite), addr: paddr, wdata: pwdata,
              strb: pstrb, prot: pprot};
      state_d   = state_q;
      req_d     = req_q;
      wait_d    = wait_q;
      first_d   = first_q;
      perr_d    = protocol_err;
      respond   = 1'b0;
      mem_we    = 1'b0;
      pready_d  = 1'b0;
      pslverr_d = SLV_OKAY;
      prdata_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = SETUP;
               req_d   = cap;
               wait_d  = cfg_wait_states;
            end else if (psel && penable) begin
               perr_d = 1'b1;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            first_d = 1'b1;
            respond = (wait_q == '0);
         end
         ACCESS: begin
            first_d = 1'b0;
            if ((!pready && !psel) || (first_q && !penable)) begin
               perr_d  = 1'b1;
               state_d = IDLE;
            end else if (!pready) begin
               wait_d  = wait_q - 1'b1;
               respond = (wait_q == WAIT_W'(1));
            end else begin
               mem_we = psel && penable && !addr_err &&
                        (req_q.write == TX_WRITE);
               if (psel && !penable) begin
                  state_d = SETUP;
                  req_d   = cap;
                  wait_d  = cfg_wait_states;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Response is registered: it appears in the next ACCESS cycle.
      if (respond) begin
         pready_d  = 1'b1;
         pslverr_d = addr_err ? SLV_ERROR : SLV_OKAY;
         if (!addr_err && req_q.write == TX_READ) begin
            prdata_d = rd_data;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q      <= IDLE;
         req_q        <= '0;
         wait_q       <= '0;
         first_q      <= 1'b0;
         pready       <= 1'b0;
         pslverr_q    <= SLV_OKAY;
         prdata       <= '0;
         protocol_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         wait_q       <= wait_d;
         first_q      <= first_d;
         pready       <= pready_d;
         pslverr_q    <= pslverr_d;
         prdata       <= prdata_d;
         protocol_err <= perr_d;
      end
   end

   assign pslverr = pslverr_q;

endmodule
